// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared ASCII constants, FSM encodings and hex helper for the
//               UART transmitter/receiver and their formatters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_X  = 8'h78;
  localparam logic [7:0] ASCII_A  = 8'h41;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10)
      return ASCII_0 + {4'h0, nib};
    else
      return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_hex_tx_fmt.sv
// ============================================================================
// Module      : uart_hex_tx_fmt
// Description : Formats one binary word as uppercase ASCII hex (optional "0x"
//               prefix, optional CR/LF) and streams it byte by byte to the UART
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_hex_tx_fmt
  import uart_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PREFIX_0X = 0,
  parameter int ADD_CRLF  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [7:0]        tx_data,
  output logic              tx_data_valid,
  input  logic              tx_data_ready,
  output logic              busy
);

  localparam int c_NDIG  = DATA_W / 4;
  localparam int c_NPFX  = 2 * PREFIX_0X;
  localparam int c_NCHAR = c_NPFX + c_NDIG + 2 * ADD_CRLF;
  localparam int c_CNT_W = $clog2(c_NCHAR + 1);

  localparam logic [c_CNT_W-1:0] c_PFX_END = c_CNT_W'(c_NPFX);
  localparam logic [c_CNT_W-1:0] c_DIG_END = c_CNT_W'(c_NPFX + c_NDIG);
  localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(c_NCHAR - 1);

  if ((DATA_W % 4) != 0 || DATA_W < 4) begin : g_bad_data_w
    $error("uart_hex_tx_fmt: DATA_W must be a positive multiple of 4");
  end

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_char_cnt;
  logic [DATA_W-1:0]  r_word;
  logic               r_word_ready;

  logic               w_accept;
  logic               w_consume;
  logic               w_in_pfx;
  logic [c_CNT_W-1:0] w_dig_idx;
  logic [3:0]         w_nib;
  logic [7:0]         w_char;

  assign w_accept  = word_valid && r_word_ready;
  assign w_consume = tx_data_valid;

  // The transmitter latches on valid alone, so valid is gated by its ready
  assign tx_data_valid = (r_state == S_EMIT) && tx_data_ready;
  assign tx_data       = w_char;
  assign busy          = (r_state == S_EMIT);
  assign word_ready    = r_word_ready;

  if (PREFIX_0X != 0) begin : g_pfx
    assign w_in_pfx = (r_char_cnt < c_PFX_END);
  end else begin : g_no_pfx
    assign w_in_pfx = 1'b0;
  end

  always_comb begin
    w_dig_idx = r_char_cnt - c_PFX_END;
    w_nib     = 4'h0;
    for (int i = 0; i < c_NDIG; i++) begin
      if (w_dig_idx == c_CNT_W'(i))
        w_nib = r_word[DATA_W-4-4*i +: 4];
    end

    w_char = 8'h00;
    if (r_state == S_EMIT) begin
      if (w_in_pfx)
        w_char = (r_char_cnt == '0) ? ASCII_0 : ASCII_X;
      else if (r_char_cnt < c_DIG_END)
        w_char = hex_to_ascii(w_nib);
      else
        w_char = (r_char_cnt == c_DIG_END) ? ASCII_CR : ASCII_LF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_char_cnt   <= '0;
      r_word       <= '0;
      r_word_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_EMIT;
            r_char_cnt   <= '0;
            r_word       <= word_data;
            r_word_ready <= 1'b0;
          end else begin
            r_word_ready <= 1'b1;
          end
        end
        S_EMIT: begin
          if (w_consume) begin
            r_char_cnt <= r_char_cnt + 1'b1;
            if (r_char_cnt == c_LAST) begin
              r_state      <= S_IDLE;
              r_word_ready <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
